bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-requester round-robin arbiter and sequencer for the team's single-port `block_ram`. After reset it zero-fills the RAM. It then shares the RAM's single port between requesters m0 and m1, with one valid/ready command channel and one read-response channel per requester. It sits directly in front of one `block_ram` instance, and all RAM strobes come from flops.

## Interface
- `WIDTH`, 16, data width; must match the attached RAM.
- `DEPTH`, 1024, RAM words; `AW = $clog2(DEPTH)` is derived and is not overridable.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mX_valid` (X = 0, 1)  in  1  command valid.
- `mX_we`  in  1  1 = write, 0 = read.
- `mX_addr`  in  AW  word address.
- `mX_wdata`  in  WIDTH  write data.
- `mX_ready`  out  1  command accepted this cycle.
- `mX_rvalid`  out  1  one-cycle read-response strobe.
- `mX_rdata`  out  WIDTH  read data; valid only while `mX_rvalid` is high.
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_read_en`  out  1  to RAM `read_en`.
- `ram_addr`  out  AW  to RAM `addr`.
- `ram_data_in`  out  WIDTH  to RAM `data_in`.
- `ram_data_out`  in  WIDTH  from RAM `data_out` (registered in the RAM, 1-edge latency).
- `init_done`  out  1  high once zero-fill is complete.

## Operation
- FSM states:
  - INIT (reset state): zero-fill the RAM.
  - RUN: arbitrate and serve requests.
  - INIT→RUN occurs on the edge that issues the write to address DEPTH-1. There is no path back to INIT except reset.
- INIT behaviour:
  - An AW-bit counter `init_cnt` runs from 0 to DEPTH-1, one write per cycle.
  - Each cycle the command register loads `write_en=1`, `addr=init_cnt`, `data_in=0`.
  - `m0_ready` and `m1_ready` are held low.
- `init_done` goes high on the cycle after the final INIT command is registered, and stays high until reset.
- Arbitration in RUN is combinational from the valids:
  - Only one requester valid: it is granted.
  - Both valid: the requester named by the priority bit `prio` is granted (0 = m0, reset value 0).
  - `mX_ready = RUN && grant_X`.
  - After every accepted command, `prio` is set to the non-granted requester. `prio` is unchanged when nothing is accepted.
- Accept means `mX_valid && mX_ready` at a rising edge. A requester must hold its command stable until accepted. `ready` may depend on `valid`.
- Command stage, loaded at the accept edge:
  - `ram_write_en` = `we`.
  - `ram_read_en` = `!we`.
  - `ram_addr` = `addr`.
  - `ram_data_in` = `wdata`.
  - `owner` = granted requester ID.
  - With no accept, both enables are registered to 0. `ram_addr` and `ram_data_in` hold their last values.
- Response stage:
  - A one-cycle delayed copy of `ram_read_en` and `owner` tracks the RAM read.
  - On the edge after the RAM samples a read, `m<owner>_rdata` is loaded from `ram_data_out` and `m<owner>_rvalid` is pulsed for one cycle.
- Responses cannot be back-pressured. Each requester receives its responses in its own issue order.
- Writes produce no response.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - All outputs are 0, including `ready`, strobes, `ram_addr`, `ram_data_in`, all `rdata` and `init_done`.
  - State is INIT, `init_cnt = 0`, `prio = 0`.
- INIT length:
  - The first RAM write strobe is registered on the first edge after `rst_n` deasserts.
  - DEPTH consecutive write strobes follow.
  - The first `ready` can be high in the cycle after the final INIT command is registered.
- Read latency: accept at edge E → `ram_read_en` high after E → RAM samples at E+1 → `rvalid` high for the cycle following E+2. Latency is 3 edges.
- Throughput: one command per cycle, sustained, regardless of read/write mix.
- Back-to-back write then read to the same address returns the new data, because the write commits at E+1 and the read samples at E+2.
- Reset mid-INIT or mid-RUN:
  - Everything restarts from INIT with a full zero-fill.
  - In-flight reads are dropped, with no `rvalid`.
- Simultaneous valids every cycle: grants strictly alternate m0, m1, m0, …
- If m1 is idle, m0 is granted every cycle and `prio` stays 1.
- Address wrap: none; the address is passed through unmodified.

## Test plan
- DEPTH=16, release reset → exactly 16 write strobes with addr 0..15 and data 0, ready low throughout, `init_done` rises the cycle after addr 15 is issued.
- After init, m0 writes 0xBEEF to addr 5, then reads addr 5 on the next cycle → `m0_rvalid` pulses 3 edges after the read accept with `m0_rdata=0xBEEF`; `m1_rvalid` stays 0.
- Both requesters hold read valids continuously (m0 addr 1, m1 addr 2) → grants alternate m0, m1, m0, m1 starting with m0; responses alternate with the correct data per owner.
- After init, m1 reads an unwritten addr 9 → `m1_rdata=0x0000`, confirming the zero-fill.
- Both requesters write the same address in the same cycle (m0 0x1111, m1 0x2222) with `prio=0`, followed by a read → the read returns 0x2222, because m0 wins first and m1 overwrites it.
- Assert `rst_n` low mid-INIT at address 7, and separately during an outstanding read → outputs go to 0 immediately; INIT restarts at addr 0; no stale `rvalid` appears.

Source files
------------

// File: rtl/bram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port block_ram.
// Zero-fills the RAM after reset, then shares its port between m0 and m1.
module bram_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_valid,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_ready,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_valid,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_ready,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             ram_write_en,
    output logic             ram_read_en,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out,
    output logic             init_done
);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_r;
    logic [AW-1:0] init_cnt_r;
    logic          prio_r;
    logic          owner_r;
    logic          rd_pend_r;
    logic          rd_owner_r;
    logic          grant0_s;
    logic          grant1_s;

    // Grant selection: a lone requester wins, a tie goes to prio_r.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (m0_valid && m1_valid) begin
                grant0_s = ~prio_r;
                grant1_s = prio_r;
            end else begin
                grant0_s = m0_valid;
                grant1_s = m1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign m0_ready = grant0_s;
    assign m1_ready = grant1_s;

    // Sequencer: zero-fill, command register, and read-response pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            init_cnt_r   <= {AW{1'b0}};
            prio_r       <= 1'b0;
            owner_r      <= 1'b0;
            rd_pend_r    <= 1'b0;
            rd_owner_r   <= 1'b0;
            ram_write_en <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_addr     <= {AW{1'b0}};
            ram_data_in  <= {WIDTH{1'b0}};
            init_done    <= 1'b0;
            m0_rvalid    <= 1'b0;
            m1_rvalid    <= 1'b0;
            m0_rdata     <= {WIDTH{1'b0}};
            m1_rdata     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    ram_write_en <= 1'b1;
                    ram_read_en  <= 1'b0;
                    ram_addr     <= init_cnt_r;
                    ram_data_in  <= {WIDTH{1'b0}};
                    owner_r      <= 1'b0;
                    init_cnt_r   <= init_cnt_r + AW'(1);
                    if (init_cnt_r == LAST_ADDR) begin
                        state_r   <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant0_s) begin
                        ram_write_en <= m0_we;
                        ram_read_en  <= ~m0_we;
                        ram_addr     <= m0_addr;
                        ram_data_in  <= m0_wdata;
                        owner_r      <= 1'b0;
                        prio_r       <= 1'b1;
                    end else if (grant1_s) begin
                        ram_write_en <= m1_we;
                        ram_read_en  <= ~m1_we;
                        ram_addr     <= m1_addr;
                        ram_data_in  <= m1_wdata;
                        owner_r      <= 1'b1;
                        prio_r       <= 1'b0;
                    end else begin
                        ram_write_en <= 1'b0;
                        ram_read_en  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_INIT;
                    ram_write_en <= 1'b0;
                    ram_read_en  <= 1'b0;
                end
            endcase

            // The RAM output is valid one edge after it samples the read.
            rd_pend_r  <= ram_read_en;
            rd_owner_r <= owner_r;
            m0_rvalid  <= rd_pend_r & ~rd_owner_r;
            m1_rvalid  <= rd_pend_r & rd_owner_r;
            if (rd_pend_r && !rd_owner_r) begin
                m0_rdata <= ram_data_out;
            end
            if (rd_pend_r && rd_owner_r) begin
                m1_rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter (DEPTH=16) with a behavioural block_ram
// attached; directed stimulus pushes expected read data, a monitor pops it.
module tb_bram_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             m0_valid = 1'b0, m0_we = 1'b0, m0_ready, m0_rvalid;
    logic [AW-1:0]    m0_addr = 4'd0;
    logic [WIDTH-1:0] m0_wdata = 16'h0, m0_rdata;
    logic             m1_valid = 1'b0, m1_we = 1'b0, m1_ready, m1_rvalid;
    logic [AW-1:0]    m1_addr = 4'd0;
    logic [WIDTH-1:0] m1_wdata = 16'h0, m1_rdata;
    logic             ram_write_en, ram_read_en, init_done;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out = 16'h0;
    logic [WIDTH-1:0] mem [DEPTH];

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    bram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with registered read, read-before-write.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
        if (ram_read_en) ram_data_out <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rvalid must match the oldest expectation of its owner.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_rvalid) begin
                if (q0.size() == 0) check("m0_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    check("m0_rdata", 32'(m0_rdata), 32'(e.d));
                    check("m0_latency", cyc, e.c);
                end
            end
            if (m1_rvalid) begin
                if (q1.size() == 0) check("m1_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("m1_rdata", 32'(m1_rdata), 32'(e.d));
                    check("m1_latency", cyc, e.c);
                end
            end
        end
    end

    task automatic push_exp(input int m, input logic [WIDTH-1:0] d);
        exp_t e;
        e.d = d;
        e.c = cyc + 3;
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Called at a negedge; holds the command until accepted, returns at the next negedge.
    task automatic send(input int m, input logic we, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd);
        bit ok = 1'b0;
        if (m == 0) begin
            m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
        for (int k = 0; k < 40; k++) begin
            #1;
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else if (!we) push_exp(m, exp_rd);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        #1;
        check("rst_wen", 32'(ram_write_en), 32'd0);
        check("rst_ren", 32'(ram_read_en), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_din", 32'(ram_data_in), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
        check("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Follows the zero-fill; abort_at >= 0 re-asserts reset at that address.
    task automatic run_init(input int abort_at);
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 4'd0;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == DEPTH - 1) begin
                m0_valid = 1'b0;
                m1_valid = 1'b0;
            end
            #1;
            check("init_wen", 32'(ram_write_en), 32'd1);
            check("init_ren", 32'(ram_read_en), 32'd0);
            check("init_addr", 32'(ram_addr), 32'(i));
            check("init_din", 32'(ram_data_in), 32'd0);
            check("init_done_flag", 32'(init_done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
            check("init_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
            if (i == abort_at) begin
                reset_dut();
                return;
            end
        end
        @(negedge clk);
        check("post_init_wen", 32'(ram_write_en), 32'd0);
        check("post_init_done", 32'(init_done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
        @(negedge clk);
        reset_dut();
        run_init(7);
        run_init(-1);

        // Write then read back-to-back on m0.
        send(0, 1'b1, 4'd5, 16'hBEEF, 16'h0);
        send(0, 1'b0, 4'd5, 16'h0, 16'hBEEF);
        m0_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Preload addr 1 and 2; the last accept is m1 so prio points at m0.
        send(0, 1'b1, 4'd1, 16'hA1A1, 16'h0);
        send(1, 1'b1, 4'd2, 16'hB2B2, 16'h0);
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 4'd1;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_ready0", 32'(m0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_ready1", 32'(m1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) push_exp(0, 16'hA1A1);
            else push_exp(1, 16'hB2B2);
            @(negedge clk);
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Unwritten address reads back as zero.
        send(1, 1'b0, 4'd9, 16'h0, 16'h0000);
        m1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Same-cycle writes to addr 3: m0 first, m1 overwrites.
        m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 4'd3; m0_wdata = 16'h1111;
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 4'd3; m1_wdata = 16'h2222;
        #1;
        check("tie_ready0", 32'(m0_ready), 32'd1);
        check("tie_ready1", 32'(m1_ready), 32'd0);
        @(negedge clk);
        m0_valid = 1'b0;
        #1;
        check("tie2_ready1", 32'(m1_ready), 32'd1);
        @(negedge clk);
        m1_valid = 1'b0;
        send(0, 1'b0, 4'd3, 16'h0, 16'h2222);
        m0_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with a read in flight: no stale rvalid, fill restarts.
        send(0, 1'b0, 4'd5, 16'h0, 16'hBEEF);
        m0_valid = 1'b0;
        reset_dut();
        run_init(-1);
        send(0, 1'b0, 4'd5, 16'h0, 16'h0000);
        m0_valid = 1'b0;
        repeat (6) @(negedge clk);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
